prog_truth_table: RTL and testbench
===================================

PROG_TRUTH_TABLE -- requirements
Module: prog_truth_table

Interface
REQ-001 SHALL have parameter N_IN, default 3, the number of logic inputs (legal 1..6).
REQ-002 SHALL have parameter RESET_TABLE, default 8'h6B, width 2**N_IN, the table loaded at reset.
REQ-003 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port in_valid  input  1  evaluation request for in_bits this cycle.
REQ-006 SHALL have port in_bits  input  N_IN  input vector; in_bits[N_IN-1] is in1 (the MSB of the index).
REQ-007 SHALL have port out_valid  output  1  pulse: out holds the result of the previous cycle's request.
REQ-008 SHALL have port out  output  1  registered truth-table result.
REQ-009 SHALL have port cfg_start  input  1  begins a serial table load.
REQ-010 SHALL have port cfg_valid  input  1  cfg_bit is valid this cycle.
REQ-011 SHALL have port cfg_bit  input  1  serial table bit, first bit = table MSB.
REQ-012 SHALL have port cfg_busy  output  1  high while a load is in progress.
REQ-013 SHALL have port cfg_done  output  1  one-cycle pulse when a new table becomes active.

Function
REQ-014 SHALL compute out = active_table[2**N_IN-1-idx], where idx = in_bits, so that the MSB is selected by input 000 (0x6B yields 0,1,1,0,1,0,1,1 for idx 0..7).
REQ-015 SHALL have a latency of exactly one cycle: in_valid at cycle t gives out_valid=1 and a valid out at t+1.
REQ-016 SHALL hold out at its last value while out_valid=0.
REQ-017 SHALL implement FSM states EVAL, LOAD and COMMIT; the reset state SHALL be EVAL.
REQ-018 SHALL go EVAL->LOAD on cfg_start, clearing the bit counter and the shadow register.
REQ-019 SHALL, in LOAD, for each cfg_valid, shift: shadow <= {shadow[W-2:0], cfg_bit} and increment the counter (W = 2**N_IN).
REQ-020 SHALL go LOAD->COMMIT in the cycle the W-th bit is accepted; cfg_valid without a bit pending in any other state SHALL be ignored.
REQ-021 SHALL, in COMMIT, copy shadow to active_table, pulse cfg_done, and return to EVAL; COMMIT lasts exactly one cycle.
REQ-022 SHALL, on cfg_start during LOAD, restart the load (counter=0, partial bits discarded, stay in LOAD).
REQ-023 SHALL ignore cfg_start during COMMIT.
REQ-024 SHALL keep evaluating in every state; requests before or during COMMIT use the old table, and requests from the cycle after COMMIT use the new one.
REQ-025 SHALL drive cfg_busy=1 in LOAD and COMMIT, and 0 in EVAL.
REQ-026 SHALL size the bit counter at N_IN+1 bits with no wrap-around; the count never exceeds W.

Reset
REQ-027 SHALL, on rst, set: out=0, out_valid=0, cfg_busy=0, cfg_done=0, state=EVAL, counter=0, shadow=0, active_table=RESET_TABLE.
REQ-028 SHALL let rst mid-LOAD abandon the load and restore RESET_TABLE (not the last committed table).
REQ-029 SHALL give rst priority over all other inputs in the same cycle.

Structure
REQ-030 SHALL place the FSM state enum and the helper function computing W from N_IN in shared package prog_tt_pkg.
REQ-031 SHALL contain one sub-module, tt_shift_loader (shadow register plus counter, with a full flag); the lookup and FSM stay in the top module.

Verification
REQ-032 SHALL cover: after reset, drive idx 0..7 with in_valid -> out sequence 0,1,1,0,1,0,1,1, each one cycle later.
REQ-033 SHALL cover: load 8'h96 (bits 1,0,0,1,0,1,1,0) -> cfg_done pulses one cycle after the 8th bit; idx 0..7 then gives 1,0,0,1,0,1,1,0.
REQ-034 SHALL cover: in_valid idx=3 in the COMMIT cycle of an 8'hFF load -> out=0 (old 0x6B table); same idx next cycle -> out=1.
REQ-035 SHALL cover: cfg_start after 5 bits, then 8 bits of 8'h00 -> the committed table is 00; only one cfg_done pulse.
REQ-036 SHALL cover: rst after 4 bits of a load -> cfg_busy=0, table=0x6B, idx 1 -> out=1.
REQ-037 SHALL cover: N_IN=2 with RESET_TABLE=4'h6 -> idx 0..3 gives 0,1,1,0; a 4-bit load commits after exactly 4 cfg_valid bits.

Source files
------------

// File: rtl/prog_tt_pkg.sv
// prog_tt_pkg
// Shared definitions for the programmable truth table: the controller
// state encoding and the helper that turns an input count into a table width.
package prog_tt_pkg;

  typedef enum logic [1:0] {
    EVAL   = 2'd0,
    LOAD   = 2'd1,
    COMMIT = 2'd2
  } tt_state_e;

  // Number of table entries for n_in logic inputs (one bit per minterm).
  function automatic int tt_width(input int n_in);
    return 1 << n_in;
  endfunction

endpackage

// File: rtl/tt_shift_loader.sv
// tt_shift_loader
// Shadow register and bit counter used while a new table is shifted in.
// Ports:
//   clk, rst      - clock and synchronous active-high reset
//   clear         - zero the shadow register and the counter
//   shift_en      - accept bit_in this cycle (shift left, bit enters at LSB)
//   bit_in        - serial table bit
//   shadow        - assembled table, first bit received ends up as MSB
//   count         - number of bits accepted since the last clear
//   full          - count has reached the table width
module tt_shift_loader
  import prog_tt_pkg::*;
#(
  parameter int N_IN = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clear,
  input  logic                        shift_en,
  input  logic                        bit_in,
  output logic [tt_width(N_IN)-1:0]   shadow,
  output logic [N_IN:0]               count,
  output logic                        full
);

  localparam int W = tt_width(N_IN);
  localparam logic [N_IN:0] CNT_ONE  = (N_IN+1)'(1);
  localparam logic [N_IN:0] CNT_FULL = (N_IN+1)'(W);

  logic [W-1:0]  shadow_q, shadow_d;
  logic [N_IN:0] count_q, count_d;

  // Clear wins over shift so a restart discards any bit offered the same cycle.
  always_comb begin
    shadow_d = shadow_q;
    count_d  = count_q;
    if (clear) begin
      shadow_d = '0;
      count_d  = '0;
    end else if (shift_en && !full) begin
      shadow_d = {shadow_q[W-2:0], bit_in};
      count_d  = count_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      count_q  <= '0;
    end else begin
      shadow_q <= shadow_d;
      count_q  <= count_d;
    end
  end

  assign full   = (count_q == CNT_FULL);
  assign shadow = shadow_q;
  assign count  = count_q;

endmodule

// File: rtl/prog_truth_table.sv
// prog_truth_table
// Registered N_IN-input truth table whose contents can be reloaded serially.
// Ports:
//   clk, rst            - clock and synchronous active-high reset
//   in_valid, in_bits   - lookup request; in_bits[N_IN-1] is the index MSB
//   out_valid, out      - result one cycle after the request; out holds otherwise
//   cfg_start           - begin (or restart) a serial table load
//   cfg_valid, cfg_bit  - serial table bits, table MSB first
//   cfg_busy            - a load is in progress (LOAD or COMMIT)
//   cfg_done            - one-cycle pulse while the new table is being committed
module prog_truth_table
  import prog_tt_pkg::*;
#(
  parameter int                        N_IN        = 3,
  parameter logic [tt_width(N_IN)-1:0] RESET_TABLE = 8'h6B
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [N_IN-1:0] in_bits,
  output logic            out_valid,
  output logic            out,
  input  logic            cfg_start,
  input  logic            cfg_valid,
  input  logic            cfg_bit,
  output logic            cfg_busy,
  output logic            cfg_done
);

  localparam int W = tt_width(N_IN);
  localparam logic [N_IN:0] LAST_CNT = (N_IN+1)'(W - 1);

  tt_state_e     state_q, state_d;
  logic [W-1:0]  active_table_q, active_table_d;
  logic          out_q, out_d;
  logic          out_valid_q, out_valid_d;

  logic          ld_clear;
  logic          ld_shift;
  logic          ld_full;
  logic [W-1:0]  ld_shadow;
  logic [N_IN:0] ld_count;

  tt_shift_loader #(
    .N_IN(N_IN)
  ) u_loader (
    .clk      (clk),
    .rst      (rst),
    .clear    (ld_clear),
    .shift_en (ld_shift),
    .bit_in   (cfg_bit),
    .shadow   (ld_shadow),
    .count    (ld_count),
    .full     (ld_full)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EVAL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: the load finishes in the cycle the final bit is accepted
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EVAL:    if (cfg_start) state_d = LOAD;
      LOAD: begin
        if (cfg_start) begin
          state_d = LOAD;
        end else if (ld_shift && (ld_count == LAST_CNT)) begin
          state_d = COMMIT;
        end
      end
      COMMIT:  state_d = EVAL;
      default: state_d = EVAL;
    endcase
  end

  // Controller outputs; cfg_start is deliberately not seen in COMMIT
  always_comb begin
    ld_clear = cfg_start && (state_q != COMMIT);
    ld_shift = (state_q == LOAD) && cfg_valid && !cfg_start && !ld_full;
    cfg_busy = (state_q != EVAL);
    cfg_done = (state_q == COMMIT);
  end

  // Lookup datapath. Entry idx lives at bit W-1-idx, which for an N_IN-bit
  // index is simply its bitwise complement. The table swaps at the end of
  // COMMIT, so a request made during COMMIT still sees the old contents.
  always_comb begin
    active_table_d = active_table_q;
    if (state_q == COMMIT) begin
      active_table_d = ld_shadow;
    end
    out_valid_d = in_valid;
    out_d       = out_q;
    if (in_valid) begin
      out_d = active_table_q[~in_bits];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_table_q <= RESET_TABLE;
      out_q          <= 1'b0;
      out_valid_q    <= 1'b0;
    end else begin
      active_table_q <= active_table_d;
      out_q          <= out_d;
      out_valid_q    <= out_valid_d;
    end
  end

  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_prog_truth_table.sv
// tb_prog_truth_table
// Drives a default (3-input, 0x6B) instance and a 2-input (0x6) instance.
// Expected lookups come from a per-instance table held as a plain vector and
// indexed arithmetically as entry[W-1-idx]; loads update it only once the
// commit cycle has passed.
module tb_prog_truth_table;

  logic       clk = 1'b0;
  logic       rst;

  logic       a_in_valid, a_out_valid, a_out;
  logic [2:0] a_in_bits;
  logic       a_cfg_start, a_cfg_valid, a_cfg_bit, a_cfg_busy, a_cfg_done;

  logic       b_in_valid, b_out_valid, b_out;
  logic [1:0] b_in_bits;
  logic       b_cfg_start, b_cfg_valid, b_cfg_bit, b_cfg_busy, b_cfg_done;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] modelA;
  logic [3:0] modelB;
  logic       lastOutA;

  prog_truth_table dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_bits(a_in_bits),
    .out_valid(a_out_valid), .out(a_out),
    .cfg_start(a_cfg_start), .cfg_valid(a_cfg_valid), .cfg_bit(a_cfg_bit),
    .cfg_busy(a_cfg_busy), .cfg_done(a_cfg_done)
  );

  prog_truth_table #(.N_IN(2), .RESET_TABLE(4'h6)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_bits(b_in_bits),
    .out_valid(b_out_valid), .out(b_out),
    .cfg_start(b_cfg_start), .cfg_valid(b_cfg_valid), .cfg_bit(b_cfg_bit),
    .cfg_busy(b_cfg_busy), .cfg_done(b_cfg_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic refA(input int idx);
    return modelA[7 - idx];
  endfunction

  function automatic logic refB(input int idx);
    return modelB[3 - idx];
  endfunction

  task automatic applyStimulus(input int idx, input string tag);
    a_in_valid = 1'b1;
    a_in_bits  = 3'(idx);
    cycle();
    a_in_valid = 1'b0;
    lastOutA   = refA(idx);
    checkOutput({tag, "_valid"}, 32'(a_out_valid), 32'd1);
    checkOutput(tag, 32'(a_out), 32'(lastOutA));
  endtask

  task automatic evalB(input int idx, input string tag);
    b_in_valid = 1'b1;
    b_in_bits  = 2'(idx);
    cycle();
    b_in_valid = 1'b0;
    checkOutput({tag, "_valid"}, 32'(b_out_valid), 32'd1);
    checkOutput(tag, 32'(b_out), 32'(refB(idx)));
  endtask

  // Full load with random idle gaps and lookups in between; optionally a
  // lookup of commitIdx lands in the commit cycle. cfg_start is held during
  // the commit cycle to show it has no effect there.
  task automatic loadA(input logic [7:0] tbl, input bit evalInCommit, input int commitIdx);
    int gaps;
    a_cfg_start = 1'b1;
    cycle();
    a_cfg_start = 1'b0;
    checkOutput("load_busy", 32'(a_cfg_busy), 32'd1);
    for (int i = 7; i >= 0; i--) begin
      gaps = $urandom_range(0, 2);
      for (int g = 0; g < gaps; g++) begin
        a_cfg_bit = 1'($urandom);
        applyStimulus($urandom_range(0, 7), "load_eval");
      end
      a_cfg_valid = 1'b1;
      a_cfg_bit   = tbl[i];
      cycle();
      a_cfg_valid = 1'b0;
      if (i > 0) begin
        checkOutput("load_done_early", 32'(a_cfg_done), 32'd0);
        checkOutput("load_busy_mid", 32'(a_cfg_busy), 32'd1);
      end
    end
    checkOutput("load_done", 32'(a_cfg_done), 32'd1);
    checkOutput("commit_busy", 32'(a_cfg_busy), 32'd1);
    a_cfg_start = 1'b1;
    if (evalInCommit) applyStimulus(commitIdx, "commit_eval");
    else cycle();
    a_cfg_start = 1'b0;
    checkOutput("post_done", 32'(a_cfg_done), 32'd0);
    checkOutput("post_busy", 32'(a_cfg_busy), 32'd0);
    modelA = tbl;
  endtask

  initial begin
    int doneCount;
    logic [7:0] tbl;
    logic [3:0] tblB;

    rst = 1'b1;
    a_in_valid = 0; a_in_bits = 0; a_cfg_start = 0; a_cfg_valid = 0; a_cfg_bit = 0;
    b_in_valid = 0; b_in_bits = 0; b_cfg_start = 0; b_cfg_valid = 0; b_cfg_bit = 0;
    modelA = 8'h6B;
    modelB = 4'h6;
    lastOutA = 1'b0;
    repeat (2) cycle();
    checkOutput("rst_out", 32'(a_out), 32'd0);
    checkOutput("rst_out_valid", 32'(a_out_valid), 32'd0);
    checkOutput("rst_busy", 32'(a_cfg_busy), 32'd0);
    checkOutput("rst_done", 32'(a_cfg_done), 32'd0);
    checkOutput("rst_b_out_valid", 32'(b_out_valid), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) applyStimulus(i, "reset_table");
    cycle();
    checkOutput("hold_valid", 32'(a_out_valid), 32'd0);
    checkOutput("hold_out", 32'(a_out), 32'(lastOutA));

    // Stray cfg_valid outside a load is ignored
    for (int i = 0; i < 4; i++) begin
      a_cfg_valid = 1'b1;
      a_cfg_bit   = 1'($urandom);
      applyStimulus($urandom_range(0, 7), "stray_cfg_eval");
      checkOutput("stray_cfg_busy", 32'(a_cfg_busy), 32'd0);
    end
    a_cfg_valid = 1'b0;

    loadA(8'h96, 1'b0, 0);
    for (int i = 0; i < 8; i++) applyStimulus(i, "table_96");

    loadA(8'h6B, 1'b0, 0);
    loadA(8'hFF, 1'b1, 3);
    checkOutput("commit_old_table", 32'(a_out), 32'd0);
    applyStimulus(3, "new_table");
    checkOutput("new_table_lit", 32'(a_out), 32'd1);

    // Restart after 5 bits, then a full load of zeros
    doneCount = 0;
    a_cfg_start = 1'b1;
    cycle();
    a_cfg_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a_cfg_valid = 1'b1;
      a_cfg_bit   = 1'($urandom);
      cycle();
      doneCount += int'(a_cfg_done);
    end
    a_cfg_valid = 1'b0;
    a_cfg_start = 1'b1;
    cycle();
    a_cfg_start = 1'b0;
    doneCount += int'(a_cfg_done);
    checkOutput("restart_busy", 32'(a_cfg_busy), 32'd1);
    for (int i = 0; i < 8; i++) begin
      a_cfg_valid = 1'b1;
      a_cfg_bit   = 1'b0;
      cycle();
      doneCount += int'(a_cfg_done);
    end
    a_cfg_valid = 1'b0;
    repeat (3) begin
      cycle();
      doneCount += int'(a_cfg_done);
    end
    checkOutput("restart_done_count", 32'(doneCount), 32'd1);
    modelA = 8'h00;
    for (int i = 0; i < 8; i++) applyStimulus(i, "table_00");

    // Reset in the middle of a load restores the reset table
    a_cfg_start = 1'b1;
    cycle();
    a_cfg_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_cfg_valid = 1'b1;
      a_cfg_bit   = 1'b1;
      cycle();
    end
    a_cfg_valid = 1'b0;
    rst = 1'b1;
    a_in_valid = 1'b1;
    cycle();
    rst = 1'b0;
    a_in_valid = 1'b0;
    checkOutput("midrst_busy", 32'(a_cfg_busy), 32'd0);
    checkOutput("midrst_out_valid", 32'(a_out_valid), 32'd0);
    checkOutput("midrst_out", 32'(a_out), 32'd0);
    modelA = 8'h6B;
    modelB = 4'h6;
    applyStimulus(1, "midrst_idx1");
    checkOutput("midrst_idx1_lit", 32'(a_out), 32'd1);
    for (int i = 0; i < 8; i++) applyStimulus(i, "midrst_table");

    // Random loads and lookups
    repeat (6) begin
      tbl = 8'($urandom);
      loadA(tbl, 1'($urandom_range(0, 1)), $urandom_range(0, 7));
      repeat (6) begin
        a_cfg_valid = 1'($urandom);
        a_cfg_bit   = 1'($urandom);
        applyStimulus($urandom_range(0, 7), "rand_eval");
      end
      a_cfg_valid = 1'b0;
    end

    // Two-input instance
    for (int i = 0; i < 4; i++) evalB(i, "b_reset_table");
    repeat (2) begin
      tblB = 4'($urandom);
      b_cfg_start = 1'b1;
      cycle();
      b_cfg_start = 1'b0;
      for (int i = 3; i >= 0; i--) begin
        b_cfg_valid = 1'b1;
        b_cfg_bit   = tblB[i];
        cycle();
        b_cfg_valid = 1'b0;
        checkOutput("b_done", 32'(b_cfg_done), (i == 0) ? 32'd1 : 32'd0);
      end
      cycle();
      checkOutput("b_post_busy", 32'(b_cfg_busy), 32'd0);
      modelB = tblB;
      for (int i = 0; i < 4; i++) evalB(i, "b_loaded_table");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
